// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between PROC_CNT processors using a
//   round-robin grant. One access is in flight at a time.
//
// Handshake (toggle req/ack):
//   A processor has a request pending while proc_req[i] != proc_ack[i]. It
//   starts a request by toggling proc_req[i]. It holds proc_we/addr/wdata
//   stable until proc_ack[i] toggles back to match. proc_ack[i] toggling marks
//   completion, and for reads proc_rdata slice i is valid from that cycle.
//
// Ports
//   clock, reset_n  : clock; asynchronous active-low reset
//   proc_req/ack    : per-processor request / completion toggles
//   proc_we         : per-processor write enable (1 = write)
//   proc_addr/wdata : flattened per-processor address / write data
//   proc_rdata      : flattened per-processor read data
//   mem_en          : one-cycle access strobe; mem_we qualifies it
//   mem_addr/wdata  : access address / write data, held until next grant
//   mem_rdata       : memory read data, MEM_LATENCY cycles after the strobe
//   busy            : arbiter is not idle
//   grant_idx       : processor being served, or last served
//   dbg_state       : current FSM state encoding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int PROC_CNT    = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PROC_CNT-1:0]          proc_req,
  input  logic [PROC_CNT-1:0]          proc_we,
  input  logic [PROC_CNT*ADDR_W-1:0]   proc_addr,
  input  logic [PROC_CNT*DATA_W-1:0]   proc_wdata,
  output logic [PROC_CNT-1:0]          proc_ack,
  output logic [PROC_CNT*DATA_W-1:0]   proc_rdata,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy,
  output logic [$clog2(PROC_CNT)-1:0]  grant_idx,
  output logic [1:0]                   dbg_state
);

  localparam int GW = $clog2(PROC_CNT);
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [PROC_CNT-1:0]         r_ack;
  logic [PROC_CNT*DATA_W-1:0]  r_rdata;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [DATA_W-1:0]           r_wdata;
  logic [GW-1:0]               r_grant;
  logic [CW-1:0]               r_cnt;

  logic [PROC_CNT-1:0]         w_pending;
  logic                        w_any;
  logic [GW-1:0]               w_win;
  logic [GW-1:0]               w_cand;
  logic                        w_wait_done;

  assign w_pending   = proc_req ^ r_ack;
  assign w_wait_done = (r_cnt == CW'(1));

  // Round-robin search: start one past the last grant and walk upward with
  // an explicit wrap, so the last-served processor is considered last.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_grant;
    w_cand = r_grant;
    for (int k = 0; k < PROC_CNT; k++) begin
      if (w_cand == GW'(PROC_CNT - 1)) begin
        w_cand = '0;
      end else begin
        w_cand = w_cand + GW'(1);
      end
      if (!w_any && w_pending[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_STROBE;
      S_STROBE: w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT:   if (w_wait_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= GW'(PROC_CNT - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_we    <= proc_we[w_win];
            r_addr  <= proc_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_wdata <= proc_wdata[int'(w_win)*DATA_W +: DATA_W];
          end
        end
        S_STROBE: begin
          if (r_we) begin
            r_ack[r_grant] <= ~r_ack[r_grant];
          end else begin
            r_cnt <= CW'(MEM_LATENCY);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          // Counter reaching zero coincides with mem_rdata being valid.
          if (w_wait_done) begin
            r_rdata[int'(r_grant)*DATA_W +: DATA_W] <= mem_rdata;
            r_ack[r_grant] <= ~r_ack[r_grant];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign proc_ack   = r_ack;
  assign proc_rdata = r_rdata;
  assign mem_en     = (r_state == S_STROBE);
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state != S_IDLE);
  assign grant_idx  = r_grant;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiter instances (MEM_LATENCY 1 and 3), each with its own memory
//   environment, requesters and a timeline reference model compared every
//   cycle, plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int P  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic              reset_n    = 1'b0;
    logic [P-1:0]      proc_req   = '0;
    logic [P-1:0]      proc_we    = '0;
    logic [P*AW-1:0]   proc_addr  = '0;
    logic [P*DW-1:0]   proc_wdata = '0;
    logic [P-1:0]      proc_ack;
    logic [P*DW-1:0]   proc_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [1:0]        grant_idx;
    logic [1:0]        dbg_state;

    logic done   = 1'b0;
    logic chk_en = 1'b0;

    mem_port_arbiter #(
      .PROC_CNT(P), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)
    ) u_dut (
      .clock(clock), .reset_n(reset_n),
      .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_ack(proc_ack), .proc_rdata(proc_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
      .grant_idx(grant_idx), .dbg_state(dbg_state)
    );

    // Memory environment: array plus LAT-deep read pipeline; garbage on
    // non-read cycles so a mistimed capture shows up.
    logic [DW-1:0] ram  [256];
    logic [DW-1:0] pipe [LAT];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clock) begin
      if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : DW'($urandom);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    // Reference model: each access is a time window. Arbitration in idle
    // cycle c gives strobe at c+1 and ack visible at c+2 (write) or
    // c+2+LAT (read); the next search starts one past the winner.
    logic [DW-1:0]   m_mem [256];
    logic [P-1:0]    m_ack      = '0;
    logic [P*DW-1:0] m_rdata    = '0;
    int              m_grant    = P - 1;
    logic            m_we       = 1'b0;
    logic [AW-1:0]   m_addr     = '0;
    logic [DW-1:0]   m_wdata    = '0;
    logic            m_active   = 1'b0;
    int              m_win      = 0;
    int              m_busy_from = -1;
    int              m_done     = 0;
    int              cyc        = 0;

    always @(posedge clock or negedge reset_n) begin
      logic [P-1:0] pend;
      int base;
      int idx;
      if (!reset_n) begin
        m_ack = '0; m_rdata = '0; m_grant = P - 1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_active = 1'b0; m_busy_from = -1; m_done = 0;
      end else begin
        if (m_active && (cyc + 1 == m_done)) begin
          m_ack[m_win] = ~m_ack[m_win];
          if (m_we) m_mem[m_addr] = m_wdata;
          else      m_rdata[m_win*DW +: DW] = m_mem[m_addr];
          m_active = 1'b0;
        end
        if (!m_active && cyc >= m_done) begin
          pend = proc_req ^ m_ack;
          base = m_grant;
          for (int k = 1; k <= P; k++) begin
            idx = (base + k) % P;
            if (!m_active && pend[idx]) begin
              m_active    = 1'b1;
              m_win       = idx;
              m_grant     = idx;
              m_we        = proc_we[idx];
              m_addr      = proc_addr[idx*AW +: AW];
              m_wdata     = proc_wdata[idx*DW +: DW];
              m_busy_from = cyc + 1;
              m_done      = cyc + (proc_we[idx] ? 2 : 2 + LAT);
            end
          end
        end
        cyc++;
      end
    end

    always @(negedge clock) begin
      if (chk_en) begin
        check($sformatf("L%0d busy@%0d", LAT, cyc), busy, (cyc >= m_busy_from) && (cyc < m_done));
        check($sformatf("L%0d mem_en@%0d", LAT, cyc), mem_en, cyc == m_busy_from);
        check($sformatf("L%0d mem_we@%0d", LAT, cyc), mem_we, m_we);
        check($sformatf("L%0d mem_addr@%0d", LAT, cyc), mem_addr, m_addr);
        check($sformatf("L%0d mem_wdata@%0d", LAT, cyc), mem_wdata, m_wdata);
        check($sformatf("L%0d grant_idx@%0d", LAT, cyc), grant_idx, m_grant);
        check($sformatf("L%0d proc_ack@%0d", LAT, cyc), proc_ack, m_ack);
        check($sformatf("L%0d proc_rdata@%0d", LAT, cyc), proc_rdata, m_rdata);
      end
    end

    logic [AW-1:0] seen_q[$];
    int            gseen_q[$];

    task automatic tick();
      @(posedge clock);
      #1;
    endtask

    task automatic neg();
      @(negedge clock);
    endtask

    task automatic do_reset();
      reset_n  = 1'b0;
      proc_req = '0;
      repeat (3) tick();
      reset_n = 1'b1;
    endtask

    task automatic req_toggle(input int p, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
      proc_we[p]             = we;
      proc_addr[p*AW +: AW]  = a;
      proc_wdata[p*DW +: DW] = d;
      proc_req[p]            = ~proc_req[p];
    endtask

    task automatic wait_ack(input int p, input int maxc, input string nm);
      logic old;
      logic seen;
      old  = proc_ack[p];
      seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
        tick();
        if (proc_ack[p] !== old) seen = 1'b1;
      end
      check($sformatf("L%0d %s", LAT, nm), seen, 1'b1);
    endtask

    task automatic collect(input int n, input int maxc);
      seen_q.delete();
      gseen_q.delete();
      for (int i = 0; i < maxc && seen_q.size() < n; i++) begin
        neg();
        if (mem_en) begin
          seen_q.push_back(mem_addr);
          gseen_q.push_back(int'(grant_idx));
        end
        tick();
      end
    endtask

    initial begin
      logic [DW-1:0] v;
      for (int a = 0; a < 256; a++) begin
        v = DW'($urandom);
        ram[a]   = v;
        m_mem[a] = v;
      end
      ram[8'h10]   = 8'hA5;
      m_mem[8'h10] = 8'hA5;
    end

    initial begin
      logic [P*DW-1:0] rd_before;
      logic [AW-1:0]   exp3 [4];
      int              i;
      reset_n  = 1'b0;
      proc_req = '0;
      tick();
      chk_en = 1'b1;

      // T1: idle after reset
      do_reset();
      check($sformatf("L%0d t1_grant_reset", LAT), grant_idx, 2'd3);
      check($sformatf("L%0d t1_rdata_reset", LAT), proc_rdata, '0);
      repeat (20) begin
        neg();
        check($sformatf("L%0d t1_mem_en", LAT), mem_en, 1'b0);
        check($sformatf("L%0d t1_busy", LAT), busy, 1'b0);
        check($sformatf("L%0d t1_ack", LAT), proc_ack, 4'b0000);
        tick();
      end

      // T2: proc2 read of 0x10 returning 0xA5
      req_toggle(2, 1'b0, 8'h10, 8'h00);
      neg();
      check($sformatf("L%0d t2_en_c0", LAT), mem_en, 1'b0);
      tick(); neg();
      check($sformatf("L%0d t2_en_c1", LAT), mem_en, 1'b1);
      check($sformatf("L%0d t2_addr_c1", LAT), mem_addr, 8'h10);
      repeat (LAT) tick();
      neg();
      check($sformatf("L%0d t2_ack_early", LAT), proc_ack[2], 1'b0);
      tick(); neg();
      check($sformatf("L%0d t2_ack", LAT), proc_ack[2], 1'b1);
      check($sformatf("L%0d t2_rdata", LAT), proc_rdata[2*DW +: DW], 8'hA5);
      tick();

      // T5: proc0 write 0x3C to 0x20, then proc1 reads it back
      rd_before = proc_rdata;
      req_toggle(0, 1'b1, 8'h20, 8'h3C);
      neg(); tick(); neg();
      check($sformatf("L%0d t5_en", LAT), mem_en, 1'b1);
      check($sformatf("L%0d t5_we", LAT), mem_we, 1'b1);
      check($sformatf("L%0d t5_addr", LAT), mem_addr, 8'h20);
      check($sformatf("L%0d t5_wdata", LAT), mem_wdata, 8'h3C);
      tick(); neg();
      check($sformatf("L%0d t5_en_off", LAT), mem_en, 1'b0);
      check($sformatf("L%0d t5_ack", LAT), proc_ack[0], 1'b1);
      check($sformatf("L%0d t5_rdata_hold", LAT), proc_rdata, rd_before);
      check($sformatf("L%0d t5_rdata2", LAT), proc_rdata[2*DW +: DW], 8'hA5);
      tick();
      req_toggle(1, 1'b0, 8'h20, 8'h00);
      wait_ack(1, 12, "t5_readback_wait");
      check($sformatf("L%0d t5_readback", LAT), proc_rdata[1*DW +: DW], 8'h3C);

      // T3: all four request together after reset
      do_reset();
      for (int p = 0; p < P; p++) begin
        exp3[p] = 8'h40 + 8'(p);
        req_toggle(p, 1'b0, exp3[p], 8'h00);
      end
      collect(4, 60);
      check($sformatf("L%0d t3_count", LAT), seen_q.size(), 4);
      for (int k = 0; k < seen_q.size(); k++) begin
        check($sformatf("L%0d t3_addr%0d", LAT, k), seen_q[k], exp3[k]);
        check($sformatf("L%0d t3_grant%0d", LAT, k), gseen_q[k], k);
      end
      for (i = 0; i < 20 && proc_ack !== 4'b1111; i++) tick();
      check($sformatf("L%0d t3_acks", LAT), proc_ack, 4'b1111);

      // T4: proc1 re-requests in its ack cycle while proc3 waits
      do_reset();
      req_toggle(1, 1'b1, 8'h51, 8'h11);
      req_toggle(3, 1'b1, 8'h53, 8'h33);
      wait_ack(1, 12, "t4_ack1_wait");
      req_toggle(1, 1'b1, 8'h61, 8'h22);
      collect(2, 30);
      check($sformatf("L%0d t4_count", LAT), seen_q.size(), 2);
      if (seen_q.size() == 2) begin
        check($sformatf("L%0d t4_first", LAT), seen_q[0], 8'h53);
        check($sformatf("L%0d t4_second", LAT), seen_q[1], 8'h61);
      end
      repeat (8) tick();

      // T6: reset while a read is waiting for data
      do_reset();
      req_toggle(2, 1'b0, 8'h33, 8'h00);
      tick(); tick();
      reset_n  = 1'b0;
      proc_req = '0;
      neg();
      check($sformatf("L%0d t6_en", LAT), mem_en, 1'b0);
      check($sformatf("L%0d t6_busy", LAT), busy, 1'b0);
      check($sformatf("L%0d t6_ack", LAT), proc_ack, 4'b0000);
      check($sformatf("L%0d t6_rdata", LAT), proc_rdata, '0);
      repeat (3) begin
        tick(); neg();
        check($sformatf("L%0d t6_ack_hold", LAT), proc_ack, 4'b0000);
      end
      tick();
      reset_n = 1'b1;
      req_toggle(0, 1'b0, 8'h10, 8'h00);
      wait_ack(0, 12, "t6_after_wait");
      check($sformatf("L%0d t6_after_rdata", LAT), proc_rdata[0 +: DW], 8'hA5);

      // Random traffic with one reset in the middle
      for (int it = 0; it < 1500; it++) begin
        if (it == 700) do_reset();
        for (int p = 0; p < P; p++) begin
          if (proc_req[p] == proc_ack[p] && $urandom_range(0, 2) == 0)
            req_toggle(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
        end
        tick();
      end
      for (i = 0; i < 300 && proc_req !== proc_ack; i++) tick();
      check($sformatf("L%0d drain", LAT), proc_req ^ proc_ack, 4'b0000);
      repeat (4) tick();
      done = 1'b1;
    end
  end

  initial begin
    int i;
    for (i = 0; i < 30000 && !(g_inst[0].done && g_inst[1].done); i++) @(posedge clock);
    check("run_complete", {g_inst[0].done, g_inst[1].done}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
